// File: rtl/flags_unit.sv
// Z/C/N/V status-flag producer with a single saved copy for exception entry/return.
// Optional FLAGS_BYPASS_EN drives flags with the post-edge value and ties pending low.
module flags_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             not_enable,
  input  logic             set_flags,
  input  logic [1:0]       op_class,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] result,
  input  logic             shifter_carry,
  input  logic [3:0]       flags_wr,
  input  logic             save,
  input  logic             restore,
  output logic [3:0]       flags,
  output logic             pending
);

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;

  logic [3:0]     flag_q;
  logic [3:0]     saved_q;
  logic [3:0]     next_flags;
  logic [WIDTH:0] sum;
  logic           z_n;
  logic           n_n;
  logic           c_n;
  logic           v_n;
  logic           do_restore;
  logic           do_set;
  logic           do_save;

  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign z_n = (result == '0);
  assign n_n = result[WIDTH-1];

  always_comb begin
    c_n = flag_q[2];
    v_n = flag_q[0];
    next_flags = {z_n, c_n, n_n, v_n};
    case (op_class)
      OP_LOGIC: begin
        c_n = shifter_carry;
        v_n = flag_q[0];
        next_flags = {z_n, c_n, n_n, v_n};
      end
      OP_ADD: begin
        c_n = sum[WIDTH];
        v_n = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
        next_flags = {z_n, c_n, n_n, v_n};
      end
      OP_SUB: begin
        // ARM-style carry on subtract is NOT borrow
        c_n = (op_a >= op_b);
        v_n = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
        next_flags = {z_n, c_n, n_n, v_n};
      end
      default: begin
        next_flags = flags_wr;
      end
    endcase
  end

  assign do_restore = !not_enable && restore;
  assign do_set     = !not_enable && set_flags && !restore;
  assign do_save    = !not_enable && save;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q  <= 4'b0000;
      saved_q <= 4'b0000;
    end else begin
      if (do_restore) begin
        flag_q <= saved_q;
      end else if (do_set) begin
        flag_q <= next_flags;
      end
      // reads pre-update flag_q, so save+restore swaps the two registers
      if (do_save) begin
        saved_q <= flag_q;
      end
    end
  end

`ifdef FLAGS_BYPASS_EN
  always_comb begin
    flags = flag_q;
    if (rst) begin
      flags = 4'b0000;
    end else if (do_restore) begin
      flags = saved_q;
    end else if (do_set) begin
      flags = next_flags;
    end
  end
  assign pending = 1'b0;
`else
  assign flags   = flag_q;
  assign pending = (set_flags || restore) && !not_enable && !rst;
`endif

endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit.
module tb_flags_unit;

`ifdef FLAGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        not_enable;
  logic        set_flags;
  logic [1:0]  op_class;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        shifter_carry;
  logic [3:0]  flags_wr;
  logic        save;
  logic        restore;
  logic [3:0]  flags;
  logic        pending;

  int errors = 0;
  int checks = 0;

  flags_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .not_enable(not_enable), .set_flags(set_flags),
    .op_class(op_class), .op_a(op_a), .op_b(op_b), .result(result),
    .shifter_carry(shifter_carry), .flags_wr(flags_wr), .save(save),
    .restore(restore), .flags(flags), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    not_enable = 1'b0; set_flags = 1'b0; op_class = 2'b00;
    op_a = '0; op_b = '0; result = '0; shifter_carry = 1'b0;
    flags_wr = 4'b0000; save = 1'b0; restore = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [1:0] cls, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic sc);
    idle();
    set_flags = 1'b1; op_class = cls; op_a = a; op_b = b; result = r; shifter_carry = sc;
  endtask

  task automatic move(input logic [3:0] v);
    idle();
    set_flags = 1'b1; op_class = 2'b11; flags_wr = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #12;
    checks++;
    if (flags !== 4'b0000 || pending !== 1'b0) begin
      errors++; $display("FAIL reset_init: flags=%b pending=%b want 0000/0", flags, pending);
    end
    rst = 1'b0;
    tick();
    move(4'b1111);
    tick();
    checks++;
    if (flags !== 4'b1111) begin
      errors++; $display("FAIL reset_pre_move: flags=%b want 1111", flags);
    end
    idle(); save = 1'b1;
    tick();
    move(4'b0101);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (flags !== 4'b0000 || pending !== 1'b0) begin
      errors++; $display("FAIL reset_async: flags=%b pending=%b want 0000/0", flags, pending);
    end
    tick();
    rst = 1'b0;
    idle(); restore = 1'b1;
    #1;
    checks++;
    if (pending !== !BYP) begin
      errors++; $display("FAIL reset_restore_pending: pending=%b want %b", pending, !BYP);
    end
    tick();
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL reset_restore: flags=%b want 0000", flags);
    end
  endtask

  task automatic test_arith();
    alu(2'b01, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    #1;
    checks++;
    if (pending !== !BYP || flags !== (BYP ? 4'b1100 : 4'b0000)) begin
      errors++; $display("FAIL add_pending: flags=%b pending=%b want %b/%b",
                         flags, pending, BYP ? 4'b1100 : 4'b0000, !BYP);
    end
    tick();
    checks++;
    if (flags !== 4'b1100) begin
      errors++; $display("FAIL add_carry_zero: flags=%b want 1100", flags);
    end
    alu(2'b01, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    tick();
    checks++;
    if (flags !== 4'b0011) begin
      errors++; $display("FAIL add_overflow: flags=%b want 0011", flags);
    end
    alu(2'b10, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0);
    tick();
    checks++;
    if (flags !== 4'b0010) begin
      errors++; $display("FAIL sub_borrow: flags=%b want 0010", flags);
    end
    alu(2'b10, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0);
    tick();
    checks++;
    if (flags !== 4'b0101) begin
      errors++; $display("FAIL sub_overflow: flags=%b want 0101", flags);
    end
    alu(2'b10, 32'h5, 32'h5, 32'h0, 1'b0);
    tick();
    checks++;
    if (flags !== 4'b1100) begin
      errors++; $display("FAIL sub_equal: flags=%b want 1100", flags);
    end
  endtask

  task automatic test_gating_logic();
    move(4'b0010);
    tick();
    move(4'b1111);
    not_enable = 1'b1;
    restore = 1'b1;
    #1;
    checks++;
    if (pending !== 1'b0 || flags !== 4'b0010) begin
      errors++; $display("FAIL gate_pending: flags=%b pending=%b want 0010/0", flags, pending);
    end
    tick();
    checks++;
    if (flags !== 4'b0010) begin
      errors++; $display("FAIL gate_hold: flags=%b want 0010", flags);
    end
    move(4'b0001);
    tick();
    alu(2'b00, 32'h0, 32'h0, 32'h8000_0000, 1'b1);
    tick();
    checks++;
    if (flags !== 4'b0111) begin
      errors++; $display("FAIL logic_carry_v: flags=%b want 0111", flags);
    end
    alu(2'b00, 32'h1234, 32'h5678, 32'h0, 1'b0);
    tick();
    checks++;
    if (flags !== 4'b1001) begin
      errors++; $display("FAIL logic_zero: flags=%b want 1001", flags);
    end
  endtask

  task automatic test_save_restore();
    move(4'b1010);
    tick();
    idle(); save = 1'b1;
    tick();
    move(4'b0101);
    tick();
    checks++;
    if (flags !== 4'b0101) begin
      errors++; $display("FAIL sr_move: flags=%b want 0101", flags);
    end
    move(4'b1111);
    restore = 1'b1;
    #1;
    checks++;
    if (flags !== (BYP ? 4'b1010 : 4'b0101)) begin
      errors++; $display("FAIL sr_restore_cycle: flags=%b want %b", flags, BYP ? 4'b1010 : 4'b0101);
    end
    tick();
    checks++;
    if (flags !== 4'b1010) begin
      errors++; $display("FAIL sr_restore: flags=%b want 1010", flags);
    end
    move(4'b0110);
    tick();
    idle(); save = 1'b1; restore = 1'b1;
    tick();
    checks++;
    if (flags !== 4'b1010) begin
      errors++; $display("FAIL swap_flags: flags=%b want 1010", flags);
    end
    idle(); restore = 1'b1;
    tick();
    checks++;
    if (flags !== 4'b0110) begin
      errors++; $display("FAIL swap_saved: flags=%b want 0110", flags);
    end
    move(4'b1111);
    save = 1'b1;
    tick();
    checks++;
    if (flags !== 4'b1111) begin
      errors++; $display("FAIL save_set_new: flags=%b want 1111", flags);
    end
    move(4'b0000);
    tick();
    idle(); restore = 1'b1;
    tick();
    checks++;
    if (flags !== 4'b0110) begin
      errors++; $display("FAIL save_set_old: flags=%b want 0110", flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      move(seq[i]);
      tick();
      checks++;
      if (flags !== seq[i]) begin
        errors++; $display("FAIL b2b_%0d: flags=%b want %b", i, flags, seq[i]);
      end
    end
    idle();
    tick();
    checks++;
    if (flags !== 4'b1000 || pending !== 1'b0) begin
      errors++; $display("FAIL b2b_hold: flags=%b pending=%b want 1000/0", flags, pending);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_gating_logic();
    test_save_restore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
